f2f_share_ctrl: RTL

Round-robin controller that shares one `fxd2flot` fixed-to-float converter among `N_REQ` requesters. Each requester presents a 19-bit fixed-point word with a valid/ready handshake. The controller grants one request at a time, holds the converter input stable for `CONV_LAT` cycles, and registers the IEEE-754 single-precision result and zero flag. It then returns them on a single response channel, tagged with the requester id. It sits between the user-project request sources and the converter datapath.

---
 rtl/f2f_pkg.sv | 21 ++
 rtl/f2f_rr_pick.sv | 51 +++++
 rtl/fxd2flot.sv | 50 +++++
 rtl/f2f_share_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/f2f_pkg.sv
// -----------------------------------------------------------------------------
// f2f_pkg
// Shared types and default widths for the shared fixed-to-float controller.
//   state_t  : controller FSM encoding (IDLE, CONV, HOLD)
//   DEF_*    : default converter widths (19-bit unsigned in, IEEE-754 single out)
//   FLOAT_W  : width of the packed float result (sign + exponent + mantissa)
// -----------------------------------------------------------------------------
package f2f_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int DEF_IN_W  = 19;
   localparam int DEF_EXP_W = 8;
   localparam int DEF_MAN_W = 23;
   localparam int FLOAT_W   = DEF_EXP_W + DEF_MAN_W + 1;

endpackage

// File: rtl/f2f_rr_pick.sv
// -----------------------------------------------------------------------------
// f2f_rr_pick
// Combinational round-robin picker.
//   valid      in  N_REQ  request vector
//   ptr        in  ID_W   highest-priority index (must be < N_REQ)
//   grant      out ID_W   first valid index at or after ptr, modulo N_REQ
//   any_valid  out 1      at least one request is valid
// -----------------------------------------------------------------------------
module f2f_rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [ID_W-1:0]  ptr,
   output logic [ID_W-1:0]  grant,
   output logic             any_valid
);

   localparam logic [ID_W:0]   N_WIDE = (ID_W + 1)'(N_REQ);
   localparam logic [ID_W-1:0] N_NARR = ID_W'(N_REQ);

   // cand[k] is the requester index searched at offset k from ptr.
   logic [ID_W-1:0] cand [N_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_cand
         localparam logic [ID_W:0]   OFF_WIDE = (ID_W + 1)'(gi);
         localparam logic [ID_W-1:0] OFF_NARR = ID_W'(gi);
         logic [ID_W:0] sum;
         assign sum = {1'b0, ptr} + OFF_WIDE;
         // ptr < N_REQ so one conditional subtraction is a full modulo;
         // narrow arithmetic is exact because the result fits in ID_W bits.
         assign cand[gi] = (sum >= N_WIDE) ? (ptr + OFF_NARR - N_NARR)
                                           : (ptr + OFF_NARR);
      end
   endgenerate

   // Walk from the farthest offset down so the nearest valid one wins.
   always_comb begin
      grant     = '0;
      any_valid = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (valid[cand[k]]) begin
            grant     = cand[k];
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fxd2flot.sv
// -----------------------------------------------------------------------------
// fxd2flot
// Combinational unsigned-integer to IEEE-754 float converter.
//   fxd_in   in  IN_W              unsigned integer
//   flt_out  out EXP_W+MAN_W+1     float, sign in MSB (always 0 here)
//   zero     out 1                 input was zero (flt_out is then all zeros)
// Bits below the leading one are left-aligned into the mantissa; when the
// input is wider than MAN_W+1 the excess low bits are truncated.
// -----------------------------------------------------------------------------
module fxd2flot #(
   parameter int IN_W  = 19,
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic [IN_W-1:0]        fxd_in,
   output logic [EXP_W+MAN_W:0]   flt_out,
   output logic                   zero
);

   localparam int BIAS = (1 << (EXP_W - 1)) - 1;

   logic [IN_W+MAN_W-1:0] wide;
   logic [MAN_W-1:0]      mant;
   logic [EXP_W-1:0]      expo;
   int                    msb;
   int                    sh;

   assign wide = {{MAN_W{1'b0}}, fxd_in};

   always_comb begin
      msb = 0;
      for (int i = 0; i < IN_W; i++) begin
         if (fxd_in[i]) begin
            msb = i;
         end
      end
      // Move the leading one to bit MAN_W so it drops off as the hidden bit.
      sh = MAN_W - msb;
      if (sh >= 0) begin
         mant = MAN_W'(wide << sh);
      end else begin
         mant = MAN_W'(wide >> (-sh));
      end
      expo = EXP_W'(BIAS + msb);
   end

   assign zero    = (fxd_in == '0);
   assign flt_out = zero ? '0 : {1'b0, expo, mant};

endmodule

// File: rtl/f2f_share_ctrl.sv
// -----------------------------------------------------------------------------
// f2f_share_ctrl
// Shares one fxd2flot converter among N_REQ requesters, one transaction at a
// time, with round-robin arbitration.
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    per-requester handshake (ready is one-hot or zero)
//   req_data               requester i on [i*IN_W +: IN_W]
//   rsp_valid/rsp_ready    response handshake
//   rsp_data/rsp_zero      registered float result and zero flag
//   rsp_id                 requester that produced the response
//   busy                   FSM is not IDLE
//   conv_count             completed responses, wraps at 16 bits
// -----------------------------------------------------------------------------
module f2f_share_ctrl
   import f2f_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int IN_W     = DEF_IN_W,
   parameter int EXP_W    = DEF_EXP_W,
   parameter int MAN_W    = DEF_MAN_W,
   parameter int CONV_LAT = 1,
   parameter int ID_W     = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*IN_W-1:0]   req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [EXP_W+MAN_W:0]    rsp_data,
   output logic                    rsp_zero,
   output logic [ID_W-1:0]         rsp_id,
   output logic                    busy,
   output logic [15:0]             conv_count
);

   localparam int                 LAT_W    = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
   localparam logic [LAT_W-1:0]   LAT_LAST = LAT_W'(CONV_LAT - 1);
   localparam logic [ID_W-1:0]    LAST_ID  = ID_W'(N_REQ - 1);

   state_t                 state_q, state_d;
   logic [ID_W-1:0]        ptr_q, ptr_d;
   logic [LAT_W-1:0]       lat_cnt_q, lat_cnt_d;
   logic [IN_W-1:0]        in_q, in_d;
   logic [ID_W-1:0]        id_q, id_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [EXP_W+MAN_W:0]   rsp_data_q, rsp_data_d;
   logic                   rsp_zero_q, rsp_zero_d;
   logic [ID_W-1:0]        rsp_id_q, rsp_id_d;
   logic [15:0]            conv_count_q, conv_count_d;

   logic [ID_W-1:0]        grant;
   logic                   any_valid;
   logic [IN_W-1:0]        req_word [N_REQ];
   logic [EXP_W+MAN_W:0]   conv_flt;
   logic                   conv_zero;

   f2f_rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .valid     (req_valid),
      .ptr       (ptr_q),
      .grant     (grant),
      .any_valid (any_valid)
   );

   // The converter only ever sees the latched word, so its input is stable
   // for the whole CONV state regardless of what requesters do.
   fxd2flot #(
      .IN_W  (IN_W),
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_conv (
      .fxd_in  (in_q),
      .flt_out (conv_flt),
      .zero    (conv_zero)
   );

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_req
         assign req_word[gi]  = req_data[gi*IN_W +: IN_W];
         // Ready depends only on state and the valid vector.
         assign req_ready[gi] = (state_q == IDLE) && any_valid &&
                                (grant == ID_W'(gi));
      end
   endgenerate

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      lat_cnt_d    = lat_cnt_q;
      in_d         = in_q;
      id_d         = id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_id_d     = rsp_id_q;
      conv_count_d = conv_count_q;

      case (state_q)
         IDLE: begin
            // The granted requester's ready equals its valid, so any valid
            // request is an accept.
            if (any_valid) begin
               in_d      = req_word[grant];
               id_d      = grant;
               ptr_d     = (grant == LAST_ID) ? '0 : grant + 1'b1;
               lat_cnt_d = '0;
               state_d   = CONV;
            end
         end
         CONV: begin
            lat_cnt_d = lat_cnt_q + 1'b1;
            if (lat_cnt_q == LAT_LAST) begin
               rsp_data_d  = conv_flt;
               rsp_zero_d  = conv_zero;
               rsp_id_d    = id_q;
               rsp_valid_d = 1'b1;
               state_d     = HOLD;
            end
         end
         HOLD: begin
            // Returning to IDLE here means the next accept is at least one
            // cycle after the response handshake.
            if (rsp_ready) begin
               rsp_valid_d  = 1'b0;
               conv_count_d = conv_count_q + 16'd1;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         lat_cnt_q    <= '0;
         in_q         <= '0;
         id_q         <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_id_q     <= '0;
         conv_count_q <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         lat_cnt_q    <= lat_cnt_d;
         in_q         <= in_d;
         id_q         <= id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_id_q     <= rsp_id_d;
         conv_count_q <= conv_count_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_id     = rsp_id_q;
   assign busy       = (state_q != IDLE);
   assign conv_count = conv_count_q;

endmodule
